render_scheduler: RTL and testbench

//   Frame-level sequencer for the ray-marching datapath. At frame start it latches the camera

---
 rtl/render_scheduler.sv | 161 ++++++++++++++++
 tb/tb_render_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/render_scheduler.sv
// Frame sequencer for the ray-marching datapath: freezes scene state per frame and
// streams raster-order pixels to a pool of marcher cores with round-robin grants.

package render_scheduler_pkg;
    localparam int unsigned COORD_W = 16;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } vec3;
endpackage

module render_scheduler
    import render_scheduler_pkg::*;
#(
    parameter int unsigned DISPLAY_WIDTH  = 320,
    parameter int unsigned DISPLAY_HEIGHT = 240,
    parameter int unsigned H_BITS         = 9,
    parameter int unsigned V_BITS         = 8,
    parameter int unsigned NUM_CORES      = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 frame_start_in,
    input  vec3                  pos_in,
    input  logic [2:0]           fractal_sel_in,
    input  logic [NUM_CORES-1:0] core_ready_in,
    output logic [NUM_CORES-1:0] core_valid_out,
    output logic [H_BITS-1:0]    hcount_out,
    output logic [V_BITS-1:0]    vcount_out,
    output vec3                  cam_pos_out,
    output logic [2:0]           fractal_sel_out,
    output logic                 frame_busy_out,
    output logic                 frame_done_out
);

    localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [H_BITS-1:0] H_LAST   = H_BITS'(DISPLAY_WIDTH - 1);
    localparam logic [V_BITS-1:0] V_LAST   = V_BITS'(DISPLAY_HEIGHT - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NUM_CORES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_DISPATCH,
        S_DRAIN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [PTR_W-1:0]     rr_ptr_q;
    logic [NUM_CORES-1:0] just_granted_q;
    logic [NUM_CORES-1:0] candidates;
    logic [NUM_CORES-1:0] grant_onehot;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     search_idx;
    logic                 grant_found;
    logic                 last_pixel;
    logic                 grant_taken;

    assign last_pixel     = (hcount_out == H_LAST) && (vcount_out == V_LAST);
    assign frame_busy_out = (state_q != S_IDLE);
    assign grant_taken    = (state_q == S_DISPATCH) && grant_found;

    // Round-robin search: first candidate at or above rr_ptr, wrapping at NUM_CORES.
    always_comb begin
        candidates  = core_ready_in & ~just_granted_q;
        grant_found = 1'b0;
        grant_idx   = '0;
        search_idx  = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (!grant_found && candidates[search_idx]) begin
                grant_found = 1'b1;
                grant_idx   = search_idx;
            end
            search_idx = (search_idx == PTR_LAST) ? '0 : search_idx + 1'b1;
        end
        grant_onehot = NUM_CORES'(1) << grant_idx;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus same-cycle dispatch strobe and done pulse; reset suppresses both.
    always_comb begin
        state_d        = state_q;
        core_valid_out = '0;
        frame_done_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start_in) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                state_d = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (grant_found) begin
                    core_valid_out = grant_onehot;
                    if (last_pixel) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (&core_ready_in) begin
                    frame_done_out = 1'b1;
                    state_d        = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (rst_in) begin
            core_valid_out = '0;
            frame_done_out = 1'b0;
        end
    end

    // Frame-scoped scene latch, raster counters and arbitration history.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cam_pos_out     <= '0;
            fractal_sel_out <= '0;
            hcount_out      <= '0;
            vcount_out      <= '0;
            rr_ptr_q        <= '0;
            just_granted_q  <= '0;
        end else begin
            just_granted_q <= core_valid_out;
            if (state_q == S_LATCH) begin
                cam_pos_out     <= pos_in;
                fractal_sel_out <= fractal_sel_in;
                hcount_out      <= '0;
                vcount_out      <= '0;
            end else if (grant_taken) begin
                rr_ptr_q <= (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
                // Counters park at zero once the final pixel leaves.
                if (last_pixel) begin
                    hcount_out <= '0;
                    vcount_out <= '0;
                end else if (hcount_out == H_LAST) begin
                    hcount_out <= '0;
                    vcount_out <= vcount_out + 1'b1;
                end else begin
                    hcount_out <= hcount_out + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_render_scheduler.sv
// Randomized directed bench for render_scheduler: a pixel-index / pointer reference
// model predicts every output each cycle.

module tb_render_scheduler;
    import render_scheduler_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned N  = 4;
    localparam int unsigned HB = 3;
    localparam int unsigned VB = 2;

    localparam int M_IDLE  = 0;
    localparam int M_LATCH = 1;
    localparam int M_DISP  = 2;
    localparam int M_DRAIN = 3;

    logic          clk_in;
    logic          rst_in;
    logic          frame_start_in;
    vec3           pos_in;
    logic [2:0]    fractal_sel_in;
    logic [N-1:0]  core_ready_in;
    logic [N-1:0]  core_valid_out;
    logic [HB-1:0] hcount_out;
    logic [VB-1:0] vcount_out;
    vec3           cam_pos_out;
    logic [2:0]    fractal_sel_out;
    logic          frame_busy_out;
    logic          frame_done_out;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model state: frame phase, next pixel index, arbitration history.
    int         m_phase;
    int         m_pix;
    int         m_rr;
    int         m_last;
    vec3        m_cam;
    logic [2:0] m_fsel;
    int         dut_grants;

    render_scheduler #(
        .DISPLAY_WIDTH (W),
        .DISPLAY_HEIGHT(H),
        .H_BITS        (HB),
        .V_BITS        (VB),
        .NUM_CORES     (N)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .frame_start_in (frame_start_in),
        .pos_in         (pos_in),
        .fractal_sel_in (fractal_sel_in),
        .core_ready_in  (core_ready_in),
        .core_valid_out (core_valid_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .cam_pos_out    (cam_pos_out),
        .fractal_sel_out(fractal_sel_out),
        .frame_busy_out (frame_busy_out),
        .frame_done_out (frame_done_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic vec3 mkv(input int a, input int b, input int c);
        vec3 v;
        v.x = COORD_W'(a);
        v.y = COORD_W'(b);
        v.z = COORD_W'(c);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_phase    = M_IDLE;
        m_pix      = 0;
        m_rr       = 0;
        m_last     = -1;
        m_cam      = '0;
        m_fsel     = '0;
        dut_grants = 0;
    endtask

    // One clock: drive inputs, predict and compare outputs, then advance the model.
    task automatic cycle(input logic rst, input logic start, input logic [N-1:0] ready,
                         input vec3 pos, input logic [2:0] fsel);
        int           win;
        logic [N-1:0] exp_valid;
        logic         exp_done;
        rst_in         = rst;
        frame_start_in = start;
        core_ready_in  = ready;
        pos_in         = pos;
        fractal_sel_in = fsel;
        #2;
        win = -1;
        if (!rst && m_phase == M_DISP) begin
            for (int k = 0; k < int'(N); k++) begin
                int c;
                c = (m_rr + k) % int'(N);
                if (win < 0 && ready[c] && c != m_last) win = c;
            end
        end
        exp_valid = (win >= 0) ? (N'(1) << win) : '0;
        exp_done  = !rst && (m_phase == M_DRAIN) && (ready == {N{1'b1}});
        chk("core_valid", 64'(core_valid_out), 64'(exp_valid));
        chk("valid_onehot0", 64'($onehot0(core_valid_out)), 64'(1));
        chk("pixel_hv", 64'({hcount_out, vcount_out}),
            64'({HB'(m_pix % int'(W)), VB'(m_pix / int'(W))}));
        chk("busy_done", 64'({frame_busy_out, frame_done_out}),
            64'({m_phase != M_IDLE, exp_done}));
        chk("latched_scene", 64'({cam_pos_out, fractal_sel_out}), 64'({m_cam, m_fsel}));
        dut_grants += $countones(core_valid_out);
        if (exp_done) chk("frame_grant_total", 64'(dut_grants), 64'(W * H));
        @(posedge clk_in);
        #1;
        if (rst) begin
            m_reset();
        end else begin
            m_last = win;
            case (m_phase)
                M_IDLE:  if (start) m_phase = M_LATCH;
                M_LATCH: begin
                    m_cam      = pos;
                    m_fsel     = fsel;
                    m_pix      = 0;
                    dut_grants = 0;
                    m_phase    = M_DISP;
                end
                M_DISP: begin
                    if (win >= 0) begin
                        m_rr  = (win + 1) % int'(N);
                        m_pix = m_pix + 1;
                        if (m_pix == int'(W * H)) begin
                            m_pix   = 0;
                            m_phase = M_DRAIN;
                        end
                    end
                end
                default: if (exp_done) m_phase = M_IDLE;
            endcase
        end
    endtask

    // Modes: 0 all ready, 1 only core0, 2 ready 1010 then stall then all,
    // 3 random everything, 4 core1 late in drain with start held, 5 reset after 3rd grant.
    task automatic run_frame(input int mode, input vec3 pos0, input logic [2:0] fs0);
        int           d;
        int           dr;
        int           n;
        logic [N-1:0] rdy;
        logic         st;
        logic         rs;
        vec3          p;
        logic [2:0]   fs;
        p = pos0;
        fs = fs0;
        cycle(1'b0, 1'b1, '1, p, fs);
        d = 0;
        dr = 0;
        n = 0;
        while (m_phase != M_IDLE && n < 300) begin
            rdy = '1;
            st  = 1'b0;
            rs  = 1'b0;
            if (m_phase == M_DISP) begin
                if (d == 2) begin
                    p  = mkv(9, 9, 9);
                    fs = 3'd7;
                end
                case (mode)
                    1: rdy = N'(1);
                    2: rdy = (d < 3) ? N'(4'b1010) : ((d < 6) ? '0 : '1);
                    3: rdy = N'($urandom);
                    5: if (dut_grants == 3) rs = 1'b1;
                    default: rdy = '1;
                endcase
                d++;
            end else if (m_phase == M_DRAIN) begin
                if (mode == 4) begin
                    st = 1'b1;
                    if (dr < 5) rdy = N'(4'b1101);
                end
                if (mode == 3) rdy = N'($urandom);
                dr++;
            end
            if (mode == 3) begin
                st = 1'($urandom);
                p  = mkv($urandom, $urandom, $urandom);
                fs = 3'($urandom);
            end
            cycle(rs, st, rdy, p, fs);
            n++;
        end
        if (n >= 300) chk("frame_timeout", 64'(frame_busy_out), 64'(0));
        repeat (2) cycle(1'b0, 1'b0, N'($urandom), mkv(-1, -2, -3), 3'd6);
    endtask

    initial begin
        m_reset();
        rst_in         = 1'b1;
        frame_start_in = 1'b0;
        core_ready_in  = '0;
        pos_in         = mkv(0, 0, 0);
        fractal_sel_in = 3'd0;
        repeat (2) @(posedge clk_in);
        #1;
        cycle(1'b1, 1'b1, '1, mkv(5, 5, 5), 3'd2);
        repeat (2) cycle(1'b0, 1'b0, '1, mkv(4, 4, 4), 3'd1);

        run_frame(2, mkv(1, 2, 3), 3'd5);
        run_frame(0, mkv(-7, 8, 100), 3'd3);
        run_frame(1, mkv(11, 22, 33), 3'd1);
        run_frame(4, mkv(40, -40, 4), 3'd4);
        run_frame(5, mkv(77, 66, 55), 3'd2);
        run_frame(0, mkv(3, 1, 4), 3'd6);
        for (int f = 0; f < 8; f++) begin
            run_frame(3, mkv($urandom, $urandom, $urandom), 3'($urandom));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
